// File: rtl/toggle_event_decoder_if.sv
// Purpose : valid/ready event channel between the toggle event decoder and
//           the main state machine.
// Signals : evt_valid  - event presented (producer -> consumer)
//           evt_code   - event code, meaningful while evt_valid
//           evt_ready  - consumer accepts the presented event
interface toggle_event_decoder_if;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ready;

    modport master (
        output evt_valid,
        output evt_code,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        output evt_ready
    );
endinterface

// File: rtl/toggle_event_decoder.sv
// Purpose : turns the six debounced toggle levels back into discrete events,
//           queues them in per-channel pending flags and hands them out one at
//           a time in fixed priority over a valid/ready channel. Edges that hit
//           an already pending channel are counted as missed.
// Ports   : clk        - system clock
//           reset      - synchronous active-high reset
//           in_toggle  - toggle levels {rst-btn, test, medicina, energia, fot, ultrasonido}
//           evt        - event channel (master side): evt_valid/evt_code out, evt_ready in
//           pending    - registered pending flags, same bit order as in_toggle
//           miss_count - per-channel saturating miss counters, channel i at [i*MISS_W +: MISS_W]
//           miss_clr   - synchronous clear of all miss counters
module toggle_event_decoder #(
    parameter int unsigned MISS_W  = 4,
    parameter logic [5:0]  CH_MASK = 6'b111111
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              in_toggle,
    toggle_event_decoder_if.master  evt,
    output logic [5:0]              pending,
    output logic [6*MISS_W-1:0]     miss_count,
    input  logic                    miss_clr
);

    localparam int unsigned        NCH      = 6;
    localparam int unsigned        RST_BIT  = 5;
    localparam logic [NCH-1:0]     RST_MASK = 6'b100000;
    localparam logic [MISS_W-1:0]  MISS_MAX = '1;

    logic [NCH-1:0]    r_s1;
    logic [NCH-1:0]    r_s2;
    logic [NCH-1:0]    r_p;
    logic [NCH-1:0]    r_pending;
    logic              r_valid;
    logic [2:0]        r_code;
    logic [MISS_W-1:0] r_miss [NCH];

    logic [NCH-1:0]    w_edge;
    logic              w_load;
    logic              w_found;
    logic [NCH-1:0]    w_sel;
    logic [2:0]        w_sel_code;
    logic              w_flush;
    logic [NCH-1:0]    w_taken;
    logic [NCH-1:0]    w_pend_nxt;
    logic [NCH-1:0]    w_miss_inc;

    // Edge detect, priority select and pending/miss next-state
    always_comb begin
        w_edge     = (r_s2 ^ r_p) & CH_MASK;
        w_load     = (r_pending != '0) && (!r_valid || evt.evt_ready);
        w_found    = 1'b0;
        w_sel      = '0;
        w_sel_code = '0;
        // Highest bit wins; code counts up from 1 as the bit index falls
        for (int i = NCH - 1; i >= 0; i--) begin
            if (r_pending[i] && !w_found) begin
                w_found    = 1'b1;
                w_sel[i]   = 1'b1;
                w_sel_code = 3'(NCH - i);
            end
        end
        w_flush = w_load && w_sel[RST_BIT];
        w_taken = w_load ? w_sel : '0;
        // A reset-button load discards every other queued and arriving event
        if (w_flush) begin
            w_pend_nxt = w_edge & RST_MASK;
        end else begin
            w_pend_nxt = (r_pending & ~w_taken) | w_edge;
        end
        w_pend_nxt = w_pend_nxt & CH_MASK;
        // An edge on the channel being loaded is a fresh event, not a miss
        w_miss_inc = w_flush ? '0 : (w_edge & r_pending & ~w_taken);
    end

    // Sync chain tracks the inputs even in reset so no stale edge survives it
    always_ff @(posedge clk) begin
        r_s1 <= in_toggle;
        r_s2 <= r_s1;
        r_p  <= r_s2;
    end

    // Pending flags and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_code    <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            if (w_load) begin
                r_valid <= 1'b1;
                r_code  <= w_sel_code;
            end else if (!r_valid || evt.evt_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Saturating miss counters; clear beats a same-edge increment
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset || miss_clr) begin
                r_miss[i] <= '0;
            end else if (w_miss_inc[i] && (r_miss[i] != MISS_MAX)) begin
                r_miss[i] <= r_miss[i] + MISS_W'(1);
            end
        end
    end

    assign pending       = r_pending;
    assign evt.evt_valid = r_valid;
    assign evt.evt_code  = r_code;

    for (genvar g = 0; g < NCH; g++) begin : g_miss
        assign miss_count[g*MISS_W +: MISS_W] = r_miss[g];
    end

endmodule
